// File: rtl/sa_ram_pkg.sv
// Shared types and helpers for the sa_ram_rws_param simple dual-port RAM model.
package sa_ram_pkg;

   typedef enum logic {ST_INIT, ST_RUN} sa_ram_state_e;

   localparam int unsigned RD_LAT_1 = 1;
   localparam int unsigned RD_LAT_2 = 2;

   // Widest data/mask the merge helper handles; callers size-cast in and out.
   localparam int unsigned MERGE_MAX_DW = 1024;
   localparam int unsigned MERGE_MAX_MW = 128;
   localparam int unsigned MERGE_DW_IW  = $clog2(MERGE_MAX_DW);
   localparam int unsigned MERGE_MW_IW  = $clog2(MERGE_MAX_MW);

   function automatic logic [MERGE_MAX_DW-1:0] lane_merge(
      input logic [MERGE_MAX_DW-1:0] old_data,
      input logic [MERGE_MAX_DW-1:0] new_data,
      input logic [MERGE_MAX_MW-1:0] mask,
      input int unsigned             mask_w,
      input int unsigned             lw
   );
      logic [MERGE_MAX_DW-1:0] bit_sel;
      int unsigned             lane;
      bit_sel = '0;
      for (int unsigned b = 0; b < MERGE_MAX_DW; b++) begin
         lane = b / lw;
         if (lane < mask_w) begin
            bit_sel[MERGE_DW_IW'(b)] = mask[MERGE_MW_IW'(lane)];
         end
      end
      return (old_data & ~bit_sel) | (new_data & bit_sel);
   endfunction

endpackage

// File: rtl/sa_ram_out_pipe.sv
// Single registered data+valid stage; data holds whenever no valid beat passes through.
module sa_ram_out_pipe
   import sa_ram_pkg::*;
#(
   parameter int unsigned DW = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] i_data,
   input  logic          i_vld,
   output logic [DW-1:0] o_data,
   output logic          o_vld
);

   logic [DW-1:0] r_data;
   logic          r_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
         r_vld  <= 1'b0;
      end else begin
         r_vld <= i_vld;
         if (i_vld) begin
            r_data <= i_data;
         end
      end
   end

   assign o_data = r_data;
   assign o_vld  = r_vld;

endmodule

// File: rtl/sa_ram_rws_param.sv
// Parametrised simple dual-port RAM with lane masks, 1/2-cycle read latency and zero-init sweep.
// Define SA_RAM_WR_BYPASS_EN for write-first same-address collisions (read-first otherwise).
module sa_ram_rws_param
   import sa_ram_pkg::*;
#(
   parameter int unsigned DW     = 64,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned AW     = 8,
   parameter int unsigned MASK_W = 8,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AW-1:0]     ra,
   input  logic              re,
   output logic [DW-1:0]     dout,
   output logic              dout_vld,
   input  logic [AW-1:0]     wa,
   input  logic              we,
   input  logic [MASK_W-1:0] wmask,
   input  logic [DW-1:0]     di,
   output logic              init_done,
   input  logic [31:0]       pwrbus_ram_pd
);

   localparam int unsigned LW = DW / MASK_W;
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (DW % MASK_W != 0) begin : g_err_dw
      $error("sa_ram_rws_param: DW must be divisible by MASK_W");
   end
   if (RD_LAT != RD_LAT_1 && RD_LAT != RD_LAT_2) begin : g_err_lat
      $error("sa_ram_rws_param: RD_LAT must be 1 or 2");
   end
   if (AW < 32 && (64'd1 << AW) < 64'(DEPTH)) begin : g_err_aw
      $error("sa_ram_rws_param: AW too narrow for DEPTH");
   end
   if (DW > MERGE_MAX_DW || MASK_W > MERGE_MAX_MW) begin : g_err_max
      $error("sa_ram_rws_param: DW or MASK_W exceeds lane_merge limits");
   end

   logic [DW-1:0] r_mem [DEPTH];

   sa_ram_state_e r_state, w_state_nxt;
   logic [AW-1:0] r_init_cnt, w_init_cnt_nxt;
   logic          r_init_done;
   logic          w_init_wr;

   logic [DW-1:0] r_rd_data;
   logic          r_rd_vld;

   logic          w_run, w_wr_en, w_rd_en, w_ra_ok;
   logic [IW-1:0] w_wa_idx, w_ra_idx, w_init_idx;
   logic [DW-1:0] w_wr_data, w_rd_raw, w_rd_word, w_rd_data;
   logic          w_unused_pwrbus;

   assign w_run      = (r_state == ST_RUN);
   assign w_wa_idx   = wa[IW-1:0];
   assign w_ra_idx   = ra[IW-1:0];
   assign w_init_idx = r_init_cnt[IW-1:0];
   assign w_ra_ok    = (32'(ra) < DEPTH);
   assign w_wr_en    = w_run && we && (32'(wa) < DEPTH);
   assign w_rd_en    = w_run && re;

   assign w_wr_data = DW'(lane_merge(MERGE_MAX_DW'(r_mem[w_wa_idx]), MERGE_MAX_DW'(di),
                                     MERGE_MAX_MW'(wmask), MASK_W, LW));
   assign w_rd_raw  = r_mem[w_ra_idx];

`ifdef SA_RAM_WR_BYPASS_EN
   // Same-cycle write to the read address forwards the merged word (write-first).
   assign w_rd_word = (we && (wa == ra)) ?
                      DW'(lane_merge(MERGE_MAX_DW'(w_rd_raw), MERGE_MAX_DW'(di),
                                     MERGE_MAX_MW'(wmask), MASK_W, LW)) : w_rd_raw;
`else
   assign w_rd_word = w_rd_raw;
`endif

   assign w_rd_data = w_ra_ok ? w_rd_word : '0;

   always_comb begin
      w_state_nxt    = r_state;
      w_init_cnt_nxt = r_init_cnt;
      w_init_wr      = 1'b0;
      unique case (r_state)
         ST_INIT: begin
            w_init_wr = 1'b1;
            if (32'(r_init_cnt) == DEPTH - 1) begin
               w_state_nxt    = ST_RUN;
               w_init_cnt_nxt = '0;
            end else begin
               w_init_cnt_nxt = r_init_cnt + 1'b1;
            end
         end
         ST_RUN: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_INIT;
         r_init_cnt  <= '0;
         r_init_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_init_cnt  <= w_init_cnt_nxt;
         r_init_done <= (w_state_nxt == ST_RUN);
      end
   end

   // Array has no reset; the sweep after every rst zeroes it instead.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_init_wr) begin
            r_mem[w_init_idx] <= '0;
         end else if (w_wr_en) begin
            r_mem[w_wa_idx] <= w_wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_data <= '0;
         r_rd_vld  <= 1'b0;
      end else begin
         r_rd_vld <= w_rd_en;
         if (w_rd_en) begin
            r_rd_data <= w_rd_data;
         end
      end
   end

   if (RD_LAT == RD_LAT_2) begin : g_lat2
      sa_ram_out_pipe #(
         .DW (DW)
      ) u_out_pipe (
         .clk    (clk),
         .rst    (rst),
         .i_data (r_rd_data),
         .i_vld  (r_rd_vld),
         .o_data (dout),
         .o_vld  (dout_vld)
      );
   end else begin : g_lat1
      assign dout     = r_rd_data;
      assign dout_vld = r_rd_vld;
   end

   assign init_done       = r_init_done;
   assign w_unused_pwrbus = ^pwrbus_ram_pd;

endmodule

// File: tb/tb_sa_ram_rws_param.sv
// Randomised + directed bench: two instances (256x64 lat 1, 200x64 lat 2) against a queue model.
module tb_sa_ram_rws_param;

   localparam int unsigned DEP_A = 256;
   localparam int unsigned DEP_B = 200;
   localparam int unsigned LAT_A = 1;
   localparam int unsigned LAT_B = 2;

   typedef struct packed {
      int          due;
      logic [63:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, re, we;
   logic [7:0]  ra, wa, wmask;
   logic [63:0] di;
   logic [31:0] pwr;
   logic [63:0] dout_a, dout_b;
   logic        vld_a, vld_b, done_a, done_b;

   always #5 clk = ~clk;

   sa_ram_rws_param #(
      .DW(64), .DEPTH(DEP_A), .AW(8), .MASK_W(8), .RD_LAT(LAT_A)
   ) u_dut_a (
      .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout_a), .dout_vld(vld_a),
      .wa(wa), .we(we), .wmask(wmask), .di(di), .init_done(done_a), .pwrbus_ram_pd(pwr)
   );

   sa_ram_rws_param #(
      .DW(64), .DEPTH(DEP_B), .AW(8), .MASK_W(8), .RD_LAT(LAT_B)
   ) u_dut_b (
      .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout_b), .dout_vld(vld_b),
      .wa(wa), .we(we), .wmask(wmask), .di(di), .init_done(done_b), .pwrbus_ram_pd(pwr)
   );

   int          n_total = 0;
   int          n_bad   = 0;
   int          cyc     = 0;
   logic [63:0] mmem [2][256];
   int          swp [2];
   logic [63:0] last [2];
   exp_t        q0[$];
   exp_t        q1[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                         input logic [7:0] m);
      logic [63:0] res;
      res = old_w;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
      end
      return res;
   endfunction

   // Spec-level model: sweep counter, array contents and a queue of due read completions.
   task automatic model_edge();
      int          dep, lat;
      logic [63:0] v;
      exp_t        e;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         dep = (d == 0) ? DEP_A : DEP_B;
         lat = (d == 0) ? LAT_A : LAT_B;
         if (rst) begin
            swp[d]  = 0;
            last[d] = '0;
            if (d == 0) q0.delete();
            else q1.delete();
         end else if (swp[d] < dep) begin
            mmem[d][swp[d]] = '0;
            swp[d]++;
         end else begin
            if (re) begin
               v = '0;
               if (int'(ra) < dep) begin
                  v = mmem[d][ra];
`ifdef SA_RAM_WR_BYPASS_EN
                  if (we && wa == ra) v = merge(v, di, wmask);
`endif
               end
               e.due  = cyc + lat - 1;
               e.data = v;
               if (d == 0) q0.push_back(e);
               else q1.push_back(e);
            end
            if (we && int'(wa) < dep) mmem[d][wa] = merge(mmem[d][wa], di, wmask);
         end
      end
   endtask

   task automatic check_dut(input int d);
      logic        have;
      logic [63:0] exp_d;
      int          dep;
      dep  = (d == 0) ? DEP_A : DEP_B;
      have = 1'b0;
      if (d == 0 && q0.size() > 0 && q0[0].due == cyc) begin
         have = 1'b1; exp_d = q0[0].data; void'(q0.pop_front());
      end else if (d == 1 && q1.size() > 0 && q1[0].due == cyc) begin
         have = 1'b1; exp_d = q1[0].data; void'(q1.pop_front());
      end
      if (have) last[d] = exp_d;
      exp_d = last[d];
      if (d == 0) begin
         check_eq("a_vld", 64'(vld_a), 64'(have));
         check_eq("a_dout", dout_a, exp_d);
         check_eq("a_init_done", 64'(done_a), 64'(swp[0] >= dep));
      end else begin
         check_eq("b_vld", 64'(vld_b), 64'(have));
         check_eq("b_dout", dout_b, exp_d);
         check_eq("b_init_done", 64'(done_b), 64'(swp[1] >= dep));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_dut(0);
      check_dut(1);
   endtask

   task automatic wait_init(input string tag);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!done_a && n < 400);
      check_eq(tag, 64'(n), 64'd256);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish, got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] col_exp;
      rst = 1'b1; re = 1'b0; we = 1'b0; ra = '0; wa = '0; wmask = '0; di = '0; pwr = '0;
      repeat (3) step();
      check_eq("rst_dout", dout_a, 64'd0);
      check_eq("rst_done", 64'(done_a), 64'd0);

      // Init sweep with a read held on address 5 throughout.
      rst = 1'b0; re = 1'b1; ra = 8'd5;
      wait_init("init_lat");
      step();
      check_eq("first_rd_vld", 64'(vld_a), 64'd1);
      check_eq("first_rd", dout_a, 64'd0);

      // Masked write.
      re = 1'b0; we = 1'b1; wa = 8'd3; wmask = 8'hFF; di = 64'h1122334455667788;
      step();
      wmask = 8'h0F; di = 64'hAAAAAAAAAAAAAAAA;
      step();
      we = 1'b0; re = 1'b1; ra = 8'd3;
      step();
      check_eq("mask_a", dout_a, 64'h11223344AAAAAAAA);
      re = 1'b0;
      step();
      check_eq("mask_b", dout_b, 64'h11223344AAAAAAAA);
      check_eq("mask_b_vld", 64'(vld_b), 64'd1);

      // Same-address collision.
`ifdef SA_RAM_WR_BYPASS_EN
      col_exp = 64'hDEADBEEF00000000;
`else
      col_exp = 64'h0;
`endif
      we = 1'b1; wa = 8'd7; wmask = 8'hFF; di = 64'hDEADBEEF00000000; re = 1'b1; ra = 8'd7;
      step();
      check_eq("coll_a", dout_a, col_exp);
      we = 1'b0; re = 1'b0;
      step();
      check_eq("coll_b", dout_b, col_exp);

      // Streaming reads.
      we = 1'b1; wmask = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         wa = 8'(i); di = 64'(i * 3);
         step();
      end
      we = 1'b0; re = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ra = 8'(i);
         step();
         check_eq("stream_a", dout_a, 64'(i * 3));
      end
      re = 1'b0;
      repeat (3) step();
      check_eq("hold_a", dout_a, 64'd27);
      check_eq("hold_a_vld", 64'(vld_a), 64'd0);
      check_eq("hold_b", dout_b, 64'd27);

      // Out-of-range access on the 200-deep instance.
      we = 1'b1; wa = 8'd50; wmask = 8'hFF; di = 64'h5050;
      step();
      wa = 8'd250; di = '1;
      step();
      we = 1'b0; re = 1'b1; ra = 8'd250;
      step();
      re = 1'b0;
      step();
      check_eq("range_b", dout_b, 64'd0);
      check_eq("range_b_vld", 64'(vld_b), 64'd1);
      re = 1'b1; ra = 8'd50;
      step();
      re = 1'b0;
      step();
      check_eq("keep_b", dout_b, 64'h5050);

      // Random traffic, with one reset in the middle of it.
      for (int i = 0; i < 700; i++) begin
         rst   = (i == 300);
         re    = 1'($urandom);
         we    = 1'($urandom);
         ra    = $urandom_range(0, 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
         wa    = $urandom_range(0, 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
         wmask = 8'($urandom);
         di    = {$urandom, $urandom};
         pwr   = $urandom;
         step();
      end
      rst = 1'b0; re = 1'b0; we = 1'b0;
      repeat (3) step();

      // Reset mid-sweep; writes attempted during the sweep must be ignored.
      rst = 1'b1;
      step();
      rst = 1'b0; re = 1'b1; ra = 8'd5; we = 1'b1; wa = 8'd9; wmask = 8'hFF; di = '1;
      repeat (100) step();
      check_eq("sweep_mid_done", 64'(done_a), 64'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      wait_init("reinit_lat");
      we = 1'b0; ra = 8'd9;
      step();
      check_eq("sweep_wr_ignored", dout_a, 64'd0);
      re = 1'b0;
      repeat (2) step();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
